// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame defaults and receiver state encoding
package uart_pkg;

  localparam int WORD_SIZE_DEF   = 8;
  localparam int NUM_SAMPLES_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    STARTING  = 2'b01,
    RECEIVING = 2'b10
  } rcvr_state_t;

endpackage

// File: rtl/uart_rcvr_datapath.sv
// rtl/uart_rcvr_datapath.sv - receiver counters, shift/data registers and status flags
module uart_rcvr_datapath
  import uart_pkg::*;
#(
  parameter int word_size   = WORD_SIZE_DEF,
  parameter int num_samples = NUM_SAMPLES_DEF,
  parameter int sample_w    = $clog2(num_samples),
  parameter int bit_w       = $clog2(word_size + 1)
) (
  input  logic                 Clock,
  input  logic                 rst_b,
  input  logic                 Serial_in,
  input  logic                 Read_ack,
  input  logic                 clr_cnt,
  input  logic                 clr_sample,
  input  logic                 inc_sample,
  input  logic                 shift_bit,
  input  logic                 stop_sample,
  output logic [sample_w-1:0]  sample_cnt,
  output logic [bit_w-1:0]     bit_cnt,
  output logic [word_size-1:0] RCV_datareg,
  output logic                 Word_ready,
  output logic                 Error1,
  output logic                 Error2
);

  logic [word_size-1:0] RCV_shftreg;

  always_ff @(posedge Clock or negedge rst_b) begin
    if (!rst_b) begin
      sample_cnt <= '0;
    end else if (clr_cnt || clr_sample) begin
      sample_cnt <= '0;
    end else if (inc_sample) begin
      sample_cnt <= sample_cnt + sample_w'(1);
    end
  end

  always_ff @(posedge Clock or negedge rst_b) begin
    if (!rst_b) begin
      bit_cnt <= '0;
    end else if (clr_cnt) begin
      bit_cnt <= '0;
    end else if (shift_bit) begin
      bit_cnt <= bit_cnt + bit_w'(1);
    end
  end

  // LSB arrives first, so after word_size shifts bit 0 sits in the LSB.
  always_ff @(posedge Clock or negedge rst_b) begin
    if (!rst_b) begin
      RCV_shftreg <= '0;
    end else if (shift_bit) begin
      RCV_shftreg <= {Serial_in, RCV_shftreg[word_size-1:1]};
    end
  end

  // An ack coinciding with the stop sample retires the old word, so no overrun.
  always_ff @(posedge Clock or negedge rst_b) begin
    if (!rst_b) begin
      RCV_datareg <= '0;
      Word_ready  <= 1'b0;
      Error1      <= 1'b0;
      Error2      <= 1'b0;
    end else if (stop_sample) begin
      RCV_datareg <= RCV_shftreg;
      Error2      <= ~Serial_in;
      Word_ready  <= 1'b1;
      Error1      <= Word_ready & ~Read_ack;
    end else if (Read_ack && Word_ready) begin
      Word_ready  <= 1'b0;
      Error1      <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rcvr.sv
// rtl/uart_rcvr.sv - oversampling UART receiver: start detection FSM around the datapath
module uart_rcvr
  import uart_pkg::*;
#(
  parameter int word_size   = WORD_SIZE_DEF,
  parameter int num_samples = NUM_SAMPLES_DEF,
  parameter int half_word   = num_samples / 2
) (
  input  logic                 Clock,
  input  logic                 rst_b,
  input  logic                 Serial_in,
  input  logic                 Read_ack,
  output logic [word_size-1:0] RCV_datareg,
  output logic                 Word_ready,
  output logic                 Error1,
  output logic                 Error2
);

  localparam int SAMPLE_W = $clog2(num_samples);
  localparam int BIT_W    = $clog2(word_size + 1);

  localparam logic [SAMPLE_W-1:0] HALF_LAST   = SAMPLE_W'(half_word - 1);
  localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(num_samples - 1);
  localparam logic [BIT_W-1:0]    WORD_BITS   = BIT_W'(word_size);

  rcvr_state_t          state, state_nxt;
  logic [SAMPLE_W-1:0]  sample_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 clr_cnt;
  logic                 clr_sample;
  logic                 inc_sample;
  logic                 shift_bit;
  logic                 stop_sample;

  always_ff @(posedge Clock or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt     = 1'b0;
    clr_sample  = 1'b0;
    inc_sample  = 1'b0;
    shift_bit   = 1'b0;
    stop_sample = 1'b0;
    case (state)
      IDLE: begin
        clr_cnt = 1'b1;
        if (!Serial_in) begin
          state_nxt = STARTING;
        end
      end
      STARTING: begin
        // A start bit must stay low until its midpoint, otherwise it was a glitch.
        if (Serial_in) begin
          clr_cnt   = 1'b1;
          state_nxt = IDLE;
        end else if (sample_cnt == HALF_LAST) begin
          clr_sample = 1'b1;
          state_nxt  = RECEIVING;
        end else begin
          inc_sample = 1'b1;
        end
      end
      RECEIVING: begin
        if (sample_cnt == SAMPLE_LAST) begin
          clr_sample = 1'b1;
          if (bit_cnt < WORD_BITS) begin
            shift_bit = 1'b1;
          end else begin
            stop_sample = 1'b1;
            clr_cnt     = 1'b1;
            state_nxt   = IDLE;
          end
        end else begin
          inc_sample = 1'b1;
        end
      end
      default: begin
        clr_cnt   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  uart_rcvr_datapath #(
    .word_size   (word_size),
    .num_samples (num_samples),
    .sample_w    (SAMPLE_W),
    .bit_w       (BIT_W)
  ) u_datapath (
    .Clock       (Clock),
    .rst_b       (rst_b),
    .Serial_in   (Serial_in),
    .Read_ack    (Read_ack),
    .clr_cnt     (clr_cnt),
    .clr_sample  (clr_sample),
    .inc_sample  (inc_sample),
    .shift_bit   (shift_bit),
    .stop_sample (stop_sample),
    .sample_cnt  (sample_cnt),
    .bit_cnt     (bit_cnt),
    .RCV_datareg (RCV_datareg),
    .Word_ready  (Word_ready),
    .Error1      (Error1),
    .Error2      (Error2)
  );

endmodule

// File: tb/tb_uart_rcvr.sv
// tb/tb_uart_rcvr.sv - randomized bench for uart_rcvr against a frame-level reference model
module tb_uart_rcvr;

  localparam int WS       = 8;
  localparam int NS       = 8;
  localparam int HALF     = NS / 2;
  localparam int STOP_OFS = HALF + (WS + 1) * NS;

  logic          Clock     = 1'b0;
  logic          rst_b     = 1'b0;
  logic          Serial_in = 1'b1;
  logic          Read_ack  = 1'b0;
  logic [WS-1:0] RCV_datareg;
  logic          Word_ready;
  logic          Error1;
  logic          Error2;

  uart_rcvr #(.word_size(WS), .num_samples(NS)) dut (
    .Clock       (Clock),
    .rst_b       (rst_b),
    .Serial_in   (Serial_in),
    .Read_ack    (Read_ack),
    .RCV_datareg (RCV_datareg),
    .Word_ready  (Word_ready),
    .Error1      (Error1),
    .Error2      (Error2)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int            cyc;
    logic [WS-1:0] data;
    logic          sb;
  } frame_t;

  frame_t        stop_q[$];
  frame_t        cur;
  int            cyc     = 0;
  int            ack_at  = -1;
  int            n_chk   = 0;
  int            n_fail  = 0;
  bit            rnd_ack = 1'b0;
  bit            chk_en  = 1'b1;
  logic [WS-1:0] m_data  = '0;
  logic          m_wr    = 1'b0;
  logic          m_e1    = 1'b0;
  logic          m_e2    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Each frame's stop-sample cycle is known from its start time; outputs follow that edge.
  always @(posedge Clock) begin
    cyc++;
    if (!rst_b) begin
      m_data = '0;
      m_wr   = 1'b0;
      m_e1   = 1'b0;
      m_e2   = 1'b0;
      stop_q.delete();
    end else if (stop_q.size() > 0 && stop_q[0].cyc == cyc) begin
      cur    = stop_q.pop_front();
      m_e1   = m_wr && !Read_ack;
      m_data = cur.data;
      m_e2   = !cur.sb;
      m_wr   = 1'b1;
    end else if (Read_ack && m_wr) begin
      m_wr = 1'b0;
      m_e1 = 1'b0;
    end
  end

  always @(posedge Clock) begin
    #2;
    if (chk_en) begin
      chk("datareg",    32'(RCV_datareg), 32'(m_data));
      chk("word_ready", 32'(Word_ready),  32'(m_wr));
      chk("error1",     32'(Error1),      32'(m_e1));
      chk("error2",     32'(Error2),      32'(m_e2));
    end
  end

  always @(negedge Clock) begin
    Read_ack = (cyc + 1 == ack_at) || (rnd_ack && $urandom_range(0, 29) == 0);
  end

  task automatic drive_bit(input logic v, input int n);
    Serial_in = v;
    repeat (n) @(negedge Clock);
  endtask

  task automatic send_frame(input logic [WS-1:0] d, input logic sb, input int stop_len, input int gap);
    frame_t f;
    if (!sb && gap < 1) gap = 1;
    f.cyc  = cyc + 1 + STOP_OFS;
    f.data = d;
    f.sb   = sb;
    stop_q.push_back(f);
    drive_bit(1'b0, NS);
    for (int k = 0; k < WS; k++) drive_bit(d[k], NS);
    drive_bit(sb, stop_len);
    if (gap > 0) drive_bit(1'b1, gap);
  endtask

  task automatic glitch(input int low_len, input int high_len);
    drive_bit(1'b0, low_len);
    drive_bit(1'b1, high_len);
  endtask

  task automatic ack_now();
    ack_at = cyc + 2;
    repeat (3) @(negedge Clock);
  endtask

  task automatic reset_mid_frame();
    drive_bit(1'b0, NS);
    for (int k = 0; k < 4; k++) drive_bit(k[0], NS);
    rst_b     = 1'b0;
    Serial_in = 1'b1;
    #1;
    chk("rst_datareg",    32'(RCV_datareg), 32'h0);
    chk("rst_word_ready", 32'(Word_ready),  32'h0);
    chk("rst_error1",     32'(Error1),      32'h0);
    chk("rst_error2",     32'(Error2),      32'h0);
    @(negedge Clock);
    rst_b = 1'b1;
    repeat (20) @(negedge Clock);
  endtask

  initial begin
    logic [WS-1:0] d;
    logic          sb;
    int            sl;
    int            gap;

    repeat (3) @(negedge Clock);
    rst_b = 1'b1;
    repeat (5) @(negedge Clock);

    send_frame(8'hA5, 1'b1, NS, 4);
    ack_now();

    glitch(2, 10);
    send_frame(8'h3C, 1'b1, NS, 4);
    ack_now();

    send_frame(8'h81, 1'b0, HALF + 1, 8);
    ack_now();

    send_frame(8'h12, 1'b1, NS, 0);
    send_frame(8'h34, 1'b1, NS, 4);
    ack_now();

    send_frame(8'h5A, 1'b1, NS, 0);
    ack_at = cyc + 1 + STOP_OFS;
    send_frame(8'hC3, 1'b1, HALF + 1, 6);
    ack_now();

    send_frame(8'h00, 1'b0, HALF + 1, 4);
    reset_mid_frame();
    send_frame(8'hFF, 1'b1, NS, 4);
    ack_now();

    rnd_ack = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) glitch($urandom_range(1, HALF), $urandom_range(2, 6));
      d   = WS'($urandom);
      sb  = ($urandom_range(0, 9) != 0);
      sl  = sb ? $urandom_range(HALF + 1, NS) : HALF + 1;
      gap = $urandom_range(sb ? 0 : 1, 10);
      send_frame(d, sb, sl, gap);
    end
    rnd_ack = 1'b0;
    repeat (100) @(negedge Clock);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rcvr.md
# uart_rcvr

Serial-to-parallel UART receiver: the receive-side counterpart of the team's UART transmitter, sharing its frame format (1 start bit low, `word_size` data bits LSB-first, 1 stop bit high). Oversamples `Serial_in` at `num_samples`× the baud rate, samples each bit at its midpoint, and presents the completed word on `RCV_datareg` with a ready/ack handshake to the host. Overrun and framing errors are flagged per word.

## Interface
- `word_size`, default 8: data bits per frame.
- `num_samples`, default 8: `Clock` cycles per bit. Must be even and ≥4.
- `half_word`, default `num_samples/2`: start-bit centring count. Derived; not overridden.

- `Clock`, input, 1: single clock, running at `num_samples` × baud.
- `rst_b`, input, 1: reset, asynchronous and active-low.
- `Serial_in`, input, 1: serial line, idle high. Already synchronised upstream.
- `Read_ack`, input, 1: one-cycle host pulse; consumes the current word.
- `RCV_datareg`, output, `word_size`: last received word.
- `Word_ready`, output, 1: high while `RCV_datareg` holds an unread word.
- `Error1`, output, 1: overrun. A new word overwrote an unread one.
- `Error2`, output, 1: framing error. The stop bit of the word in `RCV_datareg` was sampled low.

## Operation
- **State machine:** IDLE, STARTING, RECEIVING. Internal registers:
  - `sample_cnt`, clog2(`num_samples`) bits.
  - `bit_cnt`, clog2(`word_size`+1) bits.
  - `RCV_shftreg`, `word_size` bits.
- **IDLE:** counters held at 0. If `Serial_in`==0, go to STARTING.
- **STARTING:**
  - If `Serial_in`==1: false start; clear counters and go to IDLE.
  - Else if `sample_cnt`==`half_word`-1: clear `sample_cnt` and go to RECEIVING.
  - Else increment `sample_cnt`.
- **RECEIVING:** increment `sample_cnt` every cycle. On `sample_cnt`==`num_samples`-1 (the sample point), set `sample_cnt` to 0 and then:
  - If `bit_cnt`<`word_size`: right-shift `Serial_in` into the MSB of `RCV_shftreg` and increment `bit_cnt`.
  - If `bit_cnt`==`word_size` (stop-bit sample): apply the stop-sample actions below and go to IDLE.
- **Stop-sample actions:**
  - `RCV_datareg` <= `RCV_shftreg`.
  - `Error2` <= ~`Serial_in`.
  - `Word_ready` <= 1.
  - `Error1` <= `Word_ready` & ~`Read_ack`.
- **Framing error:** the word is still delivered.
- **Break condition:** the line is still low after the stop-sample. IDLE immediately re-enters STARTING. No special handling.
- **`Read_ack` with `Word_ready`=1 and no stop-sample in that cycle:** `Word_ready` <= 0 and `Error1` <= 0. `RCV_datareg` and `Error2` are held.
- **`Read_ack` in the same cycle as a stop-sample:** the old word counts as read and the new word is loaded. Result: `Word_ready`=1, `Error1`=0.
- **`Read_ack` with `Word_ready`=0:** ignored.
- **Reset:** asynchronous; state IDLE. All outputs and internal registers are 0. If reset is asserted mid-frame, the frame is discarded.
- **Releasing reset while `Serial_in` is low:** treated as a start bit. This is accepted behaviour.

## Timing
Let t0 be the first cycle IDLE samples `Serial_in`==0.
- STARTING entered at t0+1.
- RECEIVING entered at t0+`half_word`+1.
- Data bit k (k=0..`word_size`-1) is sampled at t0+`half_word`+(k+1)·`num_samples`.
- Stop-sample at t0+`half_word`+(`word_size`+1)·`num_samples`.
- `RCV_datareg`, `Word_ready`, `Error1` and `Error2` update on the following edge. With defaults: stop-sample at t0+76, outputs visible at t0+77.
- Back-to-back frames: the next start bit can be detected in the cycle after the stop-sample. The receiver tolerates a stop bit shortened to `half_word`+1 cycles.
- All outputs are registered; no combinational path from input to output.

## Structure
- Shared package `uart_pkg` holds:
  - state encodings IDLE=2'b00, STARTING=2'b01, RECEIVING=2'b10;
  - defaults `word_size`=8 and `num_samples`=8, shared with the transmitter.
- One natural sub-module, `uart_rcvr_datapath`:
  - contains `RCV_shftreg`, `RCV_datareg`, `sample_cnt`, `bit_cnt` and the status flags;
  - is driven by control strobes from the FSM in the `uart_rcvr` top.

## Test plan
- **Clean frame:** 0xA5 at 8 cycles/bit (0, 1,0,1,0,0,1,0,1, 1) → `RCV_datareg`=0xA5 and `Word_ready`=1 at t0+77; `Error1`=0, `Error2`=0. `Read_ack` → `Word_ready`=0 next cycle.
- **Glitch:** `Serial_in` low for 2 cycles then high → return to IDLE; `Word_ready` stays 0. A following frame 0x3C is received correctly.
- **Framing error:** frame 0x81 with stop bit 0 → `RCV_datareg`=0x81, `Word_ready`=1, `Error2`=1.
- **Overrun:** two back-to-back frames 0x12 then 0x34, no `Read_ack` → `RCV_datareg`=0x34, `Error1`=1. A subsequent `Read_ack` clears `Error1` and `Word_ready`.
- **Simultaneous ack and stop-sample:** `Read_ack` pulsed exactly at frame 2's stop-sample cycle → `Word_ready`=1, `Error1`=0, `RCV_datareg`=frame 2.
- **Reset mid-frame:** `rst_b` low for 1 cycle after data bit 3 → all outputs 0 immediately. A subsequent full frame 0xFF is received correctly.
